// File: rtl/fix_pkg.sv
// Shared constants and types for the FIX byte-stream framer.
package fix_pkg;

    localparam logic [7:0] SOH   = 8'h01;
    localparam logic [7:0] CH_EQ = 8'h3D;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_1  = 8'h31;
    localparam logic [7:0] CH_8  = 8'h38;
    localparam logic [7:0] CH_9  = 8'h39;

    typedef enum logic [3:0] {
        IDLE,
        SAW8,
        BODY,
        TAG1,
        TAG0,
        TAGEQ,
        DIG,
        TERM,
        DONE,
        ERR
    } framer_state_t;

    typedef enum logic [1:0] {
        ERR_DIGIT  = 2'd0,
        ERR_RANGE  = 2'd1,
        ERR_NO_SOH = 2'd2,
        ERR_LEN    = 2'd3
    } framer_err_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

endpackage

// File: rtl/fix_digit_acc.sv
// Three-digit ASCII decimal accumulator for the checksum trailer value.
// acc is 10 bits so "999" fits; the framer only looks at the low byte and
// the out-of-range flag.
module fix_digit_acc
    import fix_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       step,
    input  logic [7:0] data,
    output logic [7:0] val,
    output logic       is_dig,
    output logic       last,
    output logic       over
);

    logic [9:0] acc;
    logic [9:0] acc_nxt;
    logic [1:0] cnt;

    assign is_dig = is_digit(data);
    assign last   = (cnt == 2'd2);
    assign over   = (acc > 10'd255);
    assign val    = acc[7:0];

    // Next value: acc*10 plus the low nibble of an ASCII digit.
    always_comb begin
        acc_nxt = acc * 10'd10 + {6'd0, data[3:0]};
    end

    // Accumulator and digit counter; clear wins over step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (step) begin
            acc <= acc_nxt;
            cnt <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/fix_framer.sv
// FIX byte-stream framer: hunts "8=", forwards frame bytes with start/end
// strobes, decodes the "10=NNN<SOH>" trailer and reports framing errors.
//
// state | meaning
// IDLE  | hunting for '8'
// SAW8  | '8' seen, waiting for '='
// BODY  | inside a field value, forwarding
// TAG1  | just after SOH, '1' may start the trailer tag
// TAG0  | "SOH 1" seen, looking for '0'
// TAGEQ | "SOH 10" seen, looking for '='
// DIG   | collecting the three checksum digits
// TERM  | three digits taken, expecting the closing SOH
// DONE  | one cycle: frame_ok pulse, input not ready
// ERR   | one cycle: frame_err pulse, next byte is hunted
module fix_framer
    import fix_pkg::*;
#(
    parameter int MAX_LEN = 1024,
    parameter int LEN_W   = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       start_o,
    output logic       end_o,
    output logic [7:0] rx_checksum_o,
    output logic       frame_ok_o,
    output logic       frame_err_o,
    output logic [1:0] err_code_o
);

    framer_state_t state, state_nxt;
    framer_err_t   code_nxt, err_code_q;
    logic [LEN_W-1:0] len;
    logic accept, len_full, fwd_state;
    logic fwd, start_nxt, end_nxt, err_go;
    logic acc_clr, acc_step;
    logic [7:0] acc_val;
    logic acc_is_dig, acc_last, acc_over;

    assign ready_o  = (state != DONE);
    assign accept   = valid_i && (state != DONE);
    assign len_full = (len == LEN_W'(MAX_LEN));
    assign fwd_state = (state inside {BODY, TAG1, TAG0, TAGEQ, DIG, TERM});

    fix_digit_acc u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (acc_clr),
        .step   (acc_step),
        .data   (data_i),
        .val    (acc_val),
        .is_dig (acc_is_dig),
        .last   (acc_last),
        .over   (acc_over)
    );

    // Next-state and per-byte actions; only accepted bytes move the FSM.
    always_comb begin
        state_nxt = state;
        code_nxt  = ERR_DIGIT;
        err_go    = 1'b0;
        fwd       = 1'b0;
        start_nxt = 1'b0;
        end_nxt   = 1'b0;
        acc_clr   = 1'b0;
        acc_step  = 1'b0;

        if (accept && fwd_state && len_full) begin
            // Overflowing byte is dropped, whatever else it would have meant.
            state_nxt = ERR;
            code_nxt  = ERR_LEN;
            err_go    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && data_i == CH_8) state_nxt = SAW8;
                end
                SAW8: begin
                    if (accept) begin
                        if (data_i == CH_EQ) begin
                            state_nxt = BODY;
                            fwd       = 1'b1;
                            start_nxt = 1'b1;
                        end else if (data_i != CH_8) begin
                            state_nxt = IDLE;
                        end
                    end
                end
                BODY: begin
                    if (accept) begin
                        fwd = 1'b1;
                        if (data_i == SOH) state_nxt = TAG1;
                    end
                end
                TAG1: begin
                    if (accept) begin
                        fwd = 1'b1;
                        if (data_i == CH_1)     state_nxt = TAG0;
                        else if (data_i == SOH) state_nxt = TAG1;
                        else                    state_nxt = BODY;
                    end
                end
                TAG0: begin
                    if (accept) begin
                        fwd = 1'b1;
                        if (data_i == CH_0)     state_nxt = TAGEQ;
                        else if (data_i == SOH) state_nxt = TAG1;
                        else                    state_nxt = BODY;
                    end
                end
                TAGEQ: begin
                    if (accept) begin
                        fwd = 1'b1;
                        if (data_i == CH_EQ) begin
                            state_nxt = DIG;
                            acc_clr   = 1'b1;
                        end else if (data_i == SOH) begin
                            state_nxt = TAG1;
                        end else begin
                            state_nxt = BODY;
                        end
                    end
                end
                DIG: begin
                    if (accept) begin
                        fwd = 1'b1;
                        if (acc_is_dig) begin
                            acc_step = 1'b1;
                            if (acc_last) state_nxt = TERM;
                        end else begin
                            state_nxt = ERR;
                            code_nxt  = ERR_DIGIT;
                            err_go    = 1'b1;
                        end
                    end
                end
                TERM: begin
                    if (accept) begin
                        if (data_i == SOH) begin
                            fwd     = 1'b1;
                            end_nxt = 1'b1;
                            if (acc_over) begin
                                state_nxt = ERR;
                                code_nxt  = ERR_RANGE;
                                err_go    = 1'b1;
                            end else begin
                                state_nxt = DONE;
                            end
                        end else begin
                            state_nxt = ERR;
                            code_nxt  = ERR_NO_SOH;
                            err_go    = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                ERR: begin
                    // The byte taken during the error cycle is already hunted.
                    state_nxt = (accept && data_i == CH_8) ? SAW8 : IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Frame length: '=' loads 1, every further forwarded byte counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         len <= '0;
        else if (start_nxt) len <= LEN_W'(1);
        else if (fwd)       len <= len + LEN_W'(1);
    end

    // Registered outputs; ok/err pulses follow the one-cycle DONE/ERR states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o        <= '0;
            valid_o       <= 1'b0;
            start_o       <= 1'b0;
            end_o         <= 1'b0;
            frame_ok_o    <= 1'b0;
            frame_err_o   <= 1'b0;
            err_code_o    <= '0;
            err_code_q    <= ERR_DIGIT;
            rx_checksum_o <= '0;
        end else begin
            data_o      <= fwd ? data_i : 8'h00;
            valid_o     <= fwd;
            start_o     <= start_nxt;
            end_o       <= end_nxt;
            frame_ok_o  <= (state == DONE);
            frame_err_o <= (state == ERR);
            err_code_o  <= (state == ERR) ? err_code_q : ERR_DIGIT;
            if (err_go)         err_code_q    <= code_nxt;
            if (state == DONE)  rx_checksum_o <= acc_val;
        end
    end

endmodule

// File: tb/tb_fix_framer.sv
// Self-checking bench for fix_framer: directed frames plus random streams,
// compared against a stream-level reference parser.
`timescale 1ns/1ps
module tb_fix_framer;
    import fix_pkg::*;

    localparam int TB_MAX = 32;
    localparam int TB_LW  = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [7:0] data_o;
    logic       valid_o, start_o, end_o, frame_ok_o, frame_err_o;
    logic [7:0] rx_checksum_o;
    logic [1:0] err_code_o;

    always #5 clk = ~clk;

    fix_framer #(.MAX_LEN(TB_MAX), .LEN_W(TB_LW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .start_o       (start_o),
        .end_o         (end_o),
        .rx_checksum_o (rx_checksum_o),
        .frame_ok_o    (frame_ok_o),
        .frame_err_o   (frame_err_o),
        .err_code_o    (err_code_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] stim_q[$];
    logic [7:0] acc_q[$];
    int exp_q[$];
    int got_q[$];
    int cmp_ptr = 0;
    int ready_low_cnt = 0;
    logic prev_rlow = 1'b0;
    logic prev_end = 1'b0;
    logic pend_acc = 1'b0;
    logic [7:0] pend_byte = 8'h00;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // event: kind 0 forwarded byte, 1 frame ok (checksum), 2 frame error (code)
    function automatic int mk_ev(input int kind, input int val, input int st, input int en);
        return (kind << 12) | (st << 9) | (en << 8) | (val & 8'hFF);
    endfunction

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_q.delete();
            got_q.delete();
            cmp_ptr = 0;
            ready_low_cnt = 0;
            prev_rlow = 1'b0;
            prev_end = 1'b0;
            pend_acc = 1'b0;
        end else begin
            if (valid_o) begin
                got_q.push_back(mk_ev(0, data_o, start_o, end_o));
                chk("fwd_latency", {pend_acc, data_o}, {1'b1, pend_byte});
            end
            if (frame_ok_o) begin
                got_q.push_back(mk_ev(1, rx_checksum_o, 0, 0));
                chk("ok_after_end", prev_end, 1);
            end
            if (frame_err_o) got_q.push_back(mk_ev(2, err_code_o, 0, 0));
            if (!ready_o) begin
                ready_low_cnt++;
                chk("ready_low_one_cycle", prev_rlow, 0);
            end
            prev_rlow = !ready_o;
            prev_end  = end_o;
            pend_acc  = valid_i && ready_o;
            pend_byte = data_i;
            if (pend_acc) acc_q.push_back(data_i);
        end
    end

    function automatic logic tb_digit(input logic [7:0] b);
        return b >= 8'h30 && b <= 8'h39;
    endfunction

    // Reference: parse the whole accepted byte stream frame by frame.
    function automatic void build_expected();
        int n, i, s, t, e, lastf, endf, outc, val, idx;
        n = acc_q.size();
        i = 0;
        exp_q.delete();
        while (i < n) begin
            if (!(acc_q[i] == CH_8 && i + 1 < n && acc_q[i+1] == CH_EQ)) begin
                i++;
                continue;
            end
            s = i + 1;
            t = -1;
            for (int j = s + 1; j + 3 < n && t < 0; j++)
                if (acc_q[j] == SOH && acc_q[j+1] == CH_1 && acc_q[j+2] == CH_0 && acc_q[j+3] == CH_EQ)
                    t = j;
            e = n - 1; lastf = n - 1; endf = 0; outc = -1; val = 0;
            if (t >= 0) begin
                e = -1;
                for (int k = 0; k < 3 && e < 0; k++) begin
                    idx = t + 4 + k;
                    if (idx >= n) begin
                        e = n - 1; lastf = n - 1;
                    end else if (!tb_digit(acc_q[idx])) begin
                        e = idx; lastf = idx; outc = mk_ev(2, 0, 0, 0);
                    end else begin
                        val = val * 10 + int'(acc_q[idx]) - 48;
                    end
                end
                if (e < 0) begin
                    idx = t + 7;
                    if (idx >= n) begin
                        e = n - 1; lastf = n - 1;
                    end else if (acc_q[idx] == SOH) begin
                        e = idx; lastf = idx; endf = 1;
                        outc = (val > 255) ? mk_ev(2, 1, 0, 0) : mk_ev(1, val, 0, 0);
                    end else begin
                        e = idx; lastf = idx - 1; outc = mk_ev(2, 2, 0, 0);
                    end
                end
            end
            if (e - s + 1 > TB_MAX) begin
                e = s + TB_MAX; lastf = e - 1; endf = 0; outc = mk_ev(2, 3, 0, 0);
            end
            for (int k = s; k <= lastf; k++)
                exp_q.push_back(mk_ev(0, acc_q[k], (k == s) ? 1 : 0, (k == lastf && endf == 1) ? 1 : 0));
            if (outc >= 0) exp_q.push_back(outc);
            i = e + 1;
        end
    endfunction

    task automatic idle_cycles(input int n);
        valid_i = 1'b0;
        repeat (n) begin
            data_i = 8'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int tries = 0;
        data_i = b;
        valid_i = 1'b1;
        forever begin
            @(negedge clk);
            if (ready_o) break;
            tries++;
            if (tries > 4) begin
                chk("ready_timeout", int'(ready_o), 1);
                break;
            end
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic send_stim(input bit gaps);
        while (stim_q.size() > 0) begin
            send_byte(stim_q.pop_front());
            if (gaps && $urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end
    endtask

    task automatic push_str(input string s);
        for (int k = 0; k < s.len(); k++)
            stim_q.push_back((s[k] == 8'h5E) ? SOH : s[k]);
    endtask

    task automatic push_fill(input int n);
        repeat (n) stim_q.push_back(8'h5A);
    endtask

    task automatic check_phase(input string name, input int exp_nfwd, input int exp_last);
        int nf, nok;
        idle_cycles(4);
        build_expected();
        chk({name, "_evcount"}, got_q.size(), exp_q.size());
        for (int k = cmp_ptr; k < got_q.size() && k < exp_q.size(); k++)
            chk($sformatf("%s_ev%0d", name, k), got_q[k], exp_q[k]);
        if (exp_nfwd >= 0) begin
            nf = 0;
            for (int k = cmp_ptr; k < got_q.size(); k++)
                if ((got_q[k] >> 12) == 0) nf++;
            chk({name, "_nfwd"}, nf, exp_nfwd);
        end
        if (exp_last >= 0)
            chk({name, "_last"}, (got_q.size() > 0) ? got_q[got_q.size()-1] : -1, exp_last);
        nok = 0;
        foreach (exp_q[k]) if ((exp_q[k] >> 12) == 1) nok++;
        chk({name, "_ready_low"}, ready_low_cnt, nok);
        cmp_ptr = got_q.size();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_start"}, start_o, 0);
        chk({tag, "_end"}, end_o, 0);
        chk({tag, "_ok"}, frame_ok_o, 0);
        chk({tag, "_err"}, frame_err_o, 0);
        chk({tag, "_code"}, err_code_o, 0);
        chk({tag, "_rxcs"}, rx_checksum_o, 0);
        chk({tag, "_data"}, data_o, 0);
        chk({tag, "_ready"}, ready_o, 1);
    endtask

    task automatic gen_frame();
        string gs = "8x=1^0A";
        string vs = "0123456789AB=";
        string tags[5] = '{"9", "35", "100", "1", "49"};
        int r, v, bad;
        string dg;
        repeat ($urandom_range(0, 3)) push_str(gs.substr(0, 0 + 6).substr($urandom_range(0, 6), 0 + 0 + $urandom_range(0, 6) * 0 + 0));
        push_str("8=");
        repeat ($urandom_range(0, 3)) begin
            push_str(tags[$urandom_range(0, 4)]);
            push_str("=");
            repeat ($urandom_range(0, 5)) stim_q.push_back(vs[$urandom_range(0, vs.len() - 1)]);
            push_str("^");
        end
        if ($urandom_range(0, 7) == 0) push_fill($urandom_range(25, 40));
        r = $urandom_range(0, 9);
        if (r != 0) begin
            v = $urandom_range(0, 999);
            if ($urandom_range(0, 2) == 0) v = $urandom_range(0, 255);
            dg = $sformatf("%03d", v);
            if (r == 1) begin
                bad = $urandom_range(0, 2);
                dg = {(bad == 0) ? "x" : dg.substr(0, 0), (bad == 1) ? "x" : dg.substr(1, 1),
                      (bad == 2) ? "x" : dg.substr(2, 2)};
            end
            push_str({"10=", dg, (r == 2) ? "X" : "^"});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle_cycles(2);

        push_str("8=FIX.4.2^9=5^35=0^10=161^");
        send_stim(1'b0);
        check_phase("basic", 25, mk_ev(1, 161, 0, 0));

        push_str("xx88=A^10=007^");
        send_stim(1'b1);
        check_phase("garbage", 10, mk_ev(1, 7, 0, 0));

        push_str("8=A^100=5^1=AB^10=042^");
        send_stim(1'b1);
        check_phase("tags", 21, mk_ev(1, 42, 0, 0));

        push_str("8=B^10=2x5^");
        send_stim(1'b0);
        check_phase("bad_digit", 8, mk_ev(2, 0, 0, 0));

        push_str("8=B^10=300^");
        send_stim(1'b0);
        check_phase("range", 10, mk_ev(2, 1, 0, 0));

        push_str("8=B^10=123X");
        send_stim(1'b0);
        check_phase("no_soh", 9, mk_ev(2, 2, 0, 0));

        push_str("8="); push_fill(TB_MAX - 9); push_str("^10=123^");
        send_stim(1'b1);
        check_phase("len_max", TB_MAX, mk_ev(1, 123, 0, 0));

        push_str("8="); push_fill(TB_MAX - 8); push_str("^10=123^");
        send_stim(1'b0);
        check_phase("len_over1", TB_MAX, mk_ev(2, 3, 0, 0));

        push_str("8="); push_fill(40); push_str("^10=123^");
        send_stim(1'b1);
        check_phase("len_over", TB_MAX, mk_ev(2, 3, 0, 0));

        push_str("8=ABC^35=D");
        send_stim(1'b0);
        check_phase("pre_reset", 9, -1);
        valid_i = 1'b1;
        data_i = CH_1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        for (int k = 0; k < 4; k++) begin
            valid_i = ~valid_i;
            data_i = 8'($urandom);
            @(posedge clk); #1;
        end
        check_reset_outputs("midrst_hold");
        valid_i = 1'b0;
        rst_n = 1'b1;
        idle_cycles(1);
        push_str("8=Q^10=077^");
        send_stim(1'b1);
        check_phase("post_reset", 10, mk_ev(1, 77, 0, 0));

        for (int f = 0; f < 60; f++) begin
            gen_frame();
            send_stim(1'b1);
            if (f % 10 == 9) check_phase($sformatf("rand%0d", f), -1, -1);
        end
        push_str("x8=R^10=200^");
        send_stim(1'b1);
        check_phase("final", -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
